// File: rtl/eth_pkg.sv
// eth_pkg: shared types, constants and the nibble-wise CRC-32 step for the Ethernet transmitter
package eth_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG} tx_state_t;
  localparam logic [3:0] ETH_PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0] ETH_SFD_NIBBLE = 4'hD;
  localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
  function automatic logic [31:0] crc32_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c ^ {28'd0, d};
    for (int i = 0; i < 4; i++) r = r[0] ? (r >> 1) ^ ETH_CRC_POLY : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/eth_crc32_nibble.sv
// eth_crc32_nibble: reflected CRC-32 register advanced by one nibble per enabled cycle
module eth_crc32_nibble
  import eth_pkg::*;
(
  input  logic        rx_clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [3:0]  d,
  output logic [31:0] crc
);
  always_ff @(posedge rx_clk)
    if (reset || clear) crc <= ETH_CRC_INIT;
    else if (en) crc <= crc32_nibble(crc, d);
endmodule

// File: rtl/ethernet_tx.sv
// ethernet_tx: MII nibble transmitter (preamble, header, payload, pad, IFG)
// Define ETH_TX_FCS_EN to append the CRC-32 frame check sequence.
module ethernet_tx
  import eth_pkg::*;
#(
  parameter logic [10:0] MAX_PAYLOAD_BYTES = 11'd1500,
  parameter logic [10:0] MIN_PAYLOAD_BYTES = 11'd46,
  parameter int          IFG_NIBBLES       = 24
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [3:0]  txd,
  output logic        tx_en,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int BW = $clog2(MAX_PAYLOAD_BYTES) + 1;
  localparam logic [BW-1:0] MAX_C = BW'(MAX_PAYLOAD_BYTES);
  localparam logic [BW-1:0] MIN_C = BW'(MIN_PAYLOAD_BYTES);
  // The IDLE cycle before the next accepted start completes the gap
  localparam logic [7:0] IFG_LAST = 8'(IFG_NIBBLES - 2);
  tx_state_t state;
  logic [7:0] cnt;
  logic [111:0] hdr;
  logic [3:0] data_hi;
  logic hi, more, data_end;
  logic [BW-1:0] bcnt, bcnt_inc;
  assign bcnt_inc = bcnt + 1'b1;
  assign data_end = !s_ready && hi && ((state == PAYLOAD && bcnt >= MIN_C) || (state == PAD && bcnt_inc == MIN_C));
`ifdef ETH_TX_FCS_EN
  logic [31:0] crc, fcs_sr, fcs_now;
  eth_crc32_nibble u_crc (
    .rx_clk(rx_clk),
    .reset(reset),
    .clear(state == PREAMBLE),
    .en(state == HEADER || state == PAYLOAD || state == PAD),
    .d(txd),
    .crc(crc)
  );
  // crc still lacks the nibble on the wire at the closing edge
  assign fcs_now = ~crc32_nibble(crc, txd);
`endif
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      hi <= 1'b0;
      more <= 1'b0;
      s_ready <= 1'b0;
      txd <= 4'd0;
      tx_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= PREAMBLE;
          cnt <= '0;
          bcnt <= '0;
          hi <= 1'b0;
          busy <= 1'b1;
          tx_en <= 1'b1;
          txd <= ETH_PREAMBLE_NIBBLE;
          hdr <= {ethertype, src_mac, dst_mac};
        end
        PREAMBLE: begin
          cnt <= cnt + 8'd1;
          txd <= (cnt == 8'd14) ? ETH_SFD_NIBBLE : ETH_PREAMBLE_NIBBLE;
          if (cnt == 8'd15) begin
            state <= HEADER;
            cnt <= '0;
            txd <= hdr[3:0];
          end
        end
        HEADER: begin
          cnt <= cnt + 8'd1;
          hdr <= hdr >> 4;
          txd <= hdr[7:4];
          s_ready <= (cnt == 8'd26);
        end
        PAYLOAD: begin
          hi <= !hi;
          if (!hi) begin
            txd <= data_hi;
            s_ready <= more;
          end else begin
            txd <= 4'd0;
            state <= PAD;
          end
        end
        PAD: begin
          hi <= !hi;
          txd <= 4'd0;
          if (hi) bcnt <= bcnt_inc;
        end
`ifdef ETH_TX_FCS_EN
        FCS: begin
          cnt <= cnt + 8'd1;
          txd <= fcs_sr[3:0];
          fcs_sr <= fcs_sr >> 4;
          if (cnt == 8'd7) begin
            state <= IFG;
            cnt <= '0;
            tx_en <= 1'b0;
            txd <= 4'd0;
            done <= 1'b1;
          end
        end
`endif
        default: begin
          cnt <= cnt + 8'd1;
          if (cnt == IFG_LAST) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
      endcase
      // Byte request slot: either load the next byte or abort on underrun
      if (s_ready) begin
        s_ready <= 1'b0;
        if (s_valid) begin
          state <= PAYLOAD;
          data_hi <= s_data[7:4];
          txd <= s_data[3:0];
          hi <= 1'b0;
          bcnt <= bcnt_inc;
          more <= !s_last && bcnt_inc != MAX_C;
          err <= !s_last && bcnt_inc == MAX_C;
        end else begin
          state <= IFG;
          cnt <= '0;
          tx_en <= 1'b0;
          txd <= 4'd0;
          err <= 1'b1;
        end
      end
      if (data_end) begin
`ifdef ETH_TX_FCS_EN
        state <= FCS;
        cnt <= '0;
        txd <= fcs_now[3:0];
        fcs_sr <= fcs_now >> 4;
`else
        state <= IFG;
        cnt <= '0;
        tx_en <= 1'b0;
        txd <= 4'd0;
        done <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_ethernet_tx.sv
// tb_ethernet_tx: directed self-checking bench for ethernet_tx (MAX_PAYLOAD_BYTES=64)
module tb_ethernet_tx;
  logic rx_clk, reset, start, s_valid, s_last, s_ready, tx_en, busy, done, err;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype;
  logic [7:0] s_data;
  logic [3:0] txd;
`ifdef ETH_TX_FCS_EN
  localparam int FCS_N = 8;
`else
  localparam int FCS_N = 0;
`endif
  localparam int LEN = 136 + FCS_N;
  int checks = 0, errors = 0, cyc = 0, idle_bad = 0, bad, t_a;
  int ntx, hs, nreq, errs, dones, t_first, t_last, t_fall, t_busy, t_err, t_done;
  bit fin;
  logic [3:0] nibs [0:511];
  logic [7:0] pay [0:79];
  logic [111:0] hdrv;

  ethernet_tx #(.MAX_PAYLOAD_BYTES(11'd64)) dut (
    .rx_clk(rx_clk), .reset(reset), .start(start), .dst_mac(dst_mac), .src_mac(src_mac),
    .ethertype(ethertype), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .txd(txd), .tx_en(tx_en), .busy(busy), .done(done), .err(err)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_over(input int from, input int to);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int i = from; i < to; i++)
      for (int b = 0; b < 4; b++) begin
        fb = c[0] ^ nibs[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  // Called at a negedge; issues start and follows the frame until busy drops
  task automatic run_frame(input int nbytes, input int last_at, input int under_at, input int rst_at, input bit spam);
    bit rdy, rst_pend, seen;
    ntx = 0; hs = 0; nreq = 0; errs = 0; dones = 0; fin = 0;
    t_first = -1; t_last = -1; t_fall = -1; t_busy = -1; t_err = -1; t_done = -1;
    rdy = 0; rst_pend = 0; seen = 0;
    start = 1; s_valid = 0; s_last = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge rx_clk);
      if (rdy && s_valid) hs++;
      @(negedge rx_clk);
      cyc++;
      if (rst_pend) begin
        chk("rst_mid_tx_en", tx_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_s_ready", s_ready, 0);
        reset = 0; fin = 1;
        break;
      end
      if (busy) seen = 1;
      if (seen && !busy) begin t_busy = cyc; fin = 1; break; end
      if (tx_en) begin
        nibs[ntx] = txd; ntx++;
        if (t_first < 0) t_first = cyc;
        t_last = cyc;
      end else begin
        if (txd !== 4'd0) idle_bad++;
        if (t_first >= 0 && t_fall < 0) t_fall = cyc;
      end
      if (err) begin errs++; t_err = cyc; end
      if (done) begin dones++; t_done = cyc; end
      start = spam && (k == 50 || (!tx_en && busy));
      rdy = s_ready;
      s_valid = rdy && hs < nbytes && nreq != under_at;
      s_data = (hs < 80) ? pay[hs] : 8'h00;
      s_last = (hs == last_at);
      if (rdy) nreq++;
      if (rst_at >= 0 && hs == rst_at && !rst_pend) begin reset = 1; rst_pend = 1; end
    end
    start = 0; s_valid = 0; s_last = 0;
    chk("frame_finished", fin, 1);
  endtask

  initial begin
    reset = 1; start = 0; s_valid = 0; s_last = 0; s_data = 0;
    dst_mac = 48'h665544332211; src_mac = 48'h0C0B0A090807; ethertype = 16'h0008;
    for (int i = 0; i < 80; i++) pay[i] = 8'(i);
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    chk("reset_txd", txd, 0);
    chk("reset_tx_en", tx_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    reset = 0;
    // Minimum frame: 46 bytes 0x00..0x2D
    run_frame(46, 45, -1, -1, 0);
    chk("min_len", ntx, LEN);
    chk("min_handshakes", hs, 46);
    bad = 0;
    for (int i = 0; i < 15; i++) if (nibs[i] !== 4'h5) bad++;
    if (nibs[15] !== 4'hD) bad++;
    chk("min_preamble", bad, 0);
    hdrv = {ethertype, src_mac, dst_mac};
    bad = 0;
    for (int i = 0; i < 28; i++) if (nibs[16+i] !== hdrv[4*i +: 4]) bad++;
    chk("min_header", bad, 0);
    bad = 0;
    for (int i = 0; i < 46; i++) begin
      if (nibs[44+2*i] !== pay[i][3:0]) bad++;
      if (nibs[45+2*i] !== pay[i][7:4]) bad++;
    end
    chk("min_payload", bad, 0);
    chk("min_done", dones, 1);
    chk("min_done_first_ifg", t_done, t_fall);
    chk("min_err", errs, 0);
`ifdef ETH_TX_FCS_EN
    chk("min_fcs_residue", crc_over(16, ntx), 32'hDEBB20E3);
`endif
    // Short payload: single byte 0xAB
    pay[0] = 8'hAB;
    run_frame(1, 0, -1, -1, 0);
    pay[0] = 8'h00;
    chk("short_len", ntx, LEN);
    chk("short_lo", nibs[44], 4'hB);
    chk("short_hi", nibs[45], 4'hA);
    bad = 0;
    for (int i = 46; i < 136; i++) if (nibs[i] !== 4'h0) bad++;
    chk("short_pad", bad, 0);
    chk("short_ready_once", nreq, 1);
    chk("short_done", dones, 1);
`ifdef ETH_TX_FCS_EN
    chk("short_fcs_residue", crc_over(16, ntx), 32'hDEBB20E3);
`endif
    // Underrun at the 10th byte request
    run_frame(46, 45, 9, -1, 0);
    chk("under_len", ntx, 62);
    chk("under_handshakes", hs, 9);
    chk("under_err", errs, 1);
    chk("under_err_time", t_err, t_fall);
    chk("under_no_done", dones, 0);
    chk("under_busy_fall", t_busy - t_fall, 23);
    // Truncation: 70 bytes offered, no s_last
    run_frame(70, -1, -1, -1, 0);
    chk("trunc_handshakes", hs, 64);
    chk("trunc_err", errs, 1);
    chk("trunc_done", dones, 1);
    chk("trunc_len", ntx, 172 + FCS_N);
`ifdef ETH_TX_FCS_EN
    chk("trunc_fcs_residue", crc_over(16, ntx), 32'hDEBB20E3);
`endif
    // Back-to-back with stray starts during frame and IFG
    run_frame(46, 45, -1, -1, 1);
    chk("b2b_a_len", ntx, LEN);
    t_a = t_last;
    run_frame(46, 45, -1, -1, 0);
    chk("b2b_gap", t_first - t_a - 1, 24);
    chk("b2b_b_len", ntx, LEN);
    // Reset mid-payload, then a clean frame
    run_frame(46, 45, -1, 20, 0);
    run_frame(46, 45, -1, -1, 0);
    chk("post_rst_len", ntx, LEN);
    chk("post_rst_handshakes", hs, 46);
    chk("post_rst_done", dones, 1);
`ifdef ETH_TX_FCS_EN
    chk("post_rst_fcs_residue", crc_over(16, ntx), 32'hDEBB20E3);
`endif
    chk("idle_txd_zero", idle_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
